// File: rtl/epass_frame_reader_pkg.sv
// Shared constants, state encoding and helpers for the e-pass tag frame reader.
package epass_frame_reader_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ID_BYTES = 4;

  localparam logic [BYTE_W-1:0] SOF         = 8'hA5;
  localparam logic [BYTE_W-1:0] FEE_DEFAULT = 8'd20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_BAL  = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    StIdle = ST_IDLE,
    StId   = ST_ID,
    StBal  = ST_BAL,
    StChk  = ST_CHK,
    StHold = ST_HOLD
  } state_e;

  // States in which a frame is being received and the gap timeout applies.
  function automatic logic in_frame(input state_e s);
    return (s == StId) || (s == StBal) || (s == StChk);
  endfunction

endpackage

// File: rtl/epass_frame_reader_if.sv
// Byte-stream input, controller handshake and qualification outputs of the frame reader.
interface epass_frame_reader_if;
  import epass_frame_reader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              done;
  logic              valid_Epass;
  logic [31:0]       tag_id;
  logic [BYTE_W-1:0] balance;
  logic              frame_err;
  logic              low_bal;
  logic              busy;

  // Producer of bytes and of the controller's done indication.
  modport master (
    output rx_valid, rx_data, done,
    input  valid_Epass, tag_id, balance, frame_err, low_bal, busy
  );

  // The frame reader itself.
  modport slave (
    input  rx_valid, rx_data, done,
    output valid_Epass, tag_id, balance, frame_err, low_bal, busy
  );

endinterface

// File: rtl/epass_frame_reader_timer.sv
// Clearable up-counter with a terminal-count compare; shared for gap and hold timing.
module epass_frame_reader_timer #(
  parameter int unsigned Width = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/epass_frame_reader.sv
// Parses tag frames from the transceiver byte stream, checks checksum and balance, and holds
// valid_Epass until the toll controller reports done or the hold window expires.
module epass_frame_reader
  import epass_frame_reader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] FEE         = FEE_DEFAULT,
  parameter int unsigned       GAP_CYCLES  = 500000,
  parameter int unsigned       HOLD_CYCLES = 100000000,
  parameter int unsigned       WIDTH_TMR   = 27
) (
  input logic                 clk,
  input logic                 reset,
  epass_frame_reader_if.slave bus
);

  localparam logic [WIDTH_TMR-1:0] GapLimit  = WIDTH_TMR'(GAP_CYCLES - 1);
  localparam logic [WIDTH_TMR-1:0] HoldLimit = WIDTH_TMR'(HOLD_CYCLES - 1);

  state_e            state;
  logic [1:0]        byte_cnt;
  logic [31:0]       id_shadow;
  logic [BYTE_W-1:0] bal_shadow;
  logic [BYTE_W-1:0] sum;

  logic              valid_q;
  logic [31:0]       tag_id_q;
  logic [BYTE_W-1:0] balance_q;
  logic              frame_err_q;
  logic              low_bal_q;

  logic                 framing;
  logic                 gap_expired;
  logic                 hold_exit;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_tc;
  logic [WIDTH_TMR-1:0] tmr_limit;

  // Timer control: a received byte beats a same-cycle gap expiry, and the timer is held at
  // zero whenever the FSM is idle or about to leave a timed state.
  always_comb begin
    framing     = in_frame(state);
    tmr_limit   = (state == StHold) ? HoldLimit : GapLimit;
    gap_expired = framing && tmr_tc && !bus.rx_valid;
    hold_exit   = (state == StHold) && (bus.done || tmr_tc);
    tmr_clr     = (state == StIdle) || (framing && (bus.rx_valid || gap_expired)) || hold_exit;
    tmr_en      = !tmr_clr;
  end

  epass_frame_reader_timer #(
    .Width (WIDTH_TMR)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  // Frame parser FSM with registered qualification outputs and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      byte_cnt    <= '0;
      id_shadow   <= '0;
      bal_shadow  <= '0;
      sum         <= '0;
      valid_q     <= 1'b0;
      tag_id_q    <= '0;
      balance_q   <= '0;
      frame_err_q <= 1'b0;
      low_bal_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      low_bal_q   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.rx_valid && (bus.rx_data == SOF)) begin
            state    <= StId;
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        StId: begin
          if (bus.rx_valid) begin
            // SOF value inside a frame is plain data; no resync.
            id_shadow <= {id_shadow[23:0], bus.rx_data};
            sum       <= sum ^ bus.rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'(ID_BYTES - 1)) begin
              state <= StBal;
            end
          end else if (gap_expired) begin
            frame_err_q <= 1'b1;
            id_shadow   <= '0;
            bal_shadow  <= '0;
            state       <= StIdle;
          end
        end
        StBal: begin
          if (bus.rx_valid) begin
            bal_shadow <= bus.rx_data;
            sum        <= sum ^ bus.rx_data;
            state      <= StChk;
          end else if (gap_expired) begin
            frame_err_q <= 1'b1;
            id_shadow   <= '0;
            bal_shadow  <= '0;
            state       <= StIdle;
          end
        end
        StChk: begin
          if (bus.rx_valid) begin
            if (bus.rx_data != sum) begin
              frame_err_q <= 1'b1;
              state       <= StIdle;
            end else if (bal_shadow < FEE) begin
              low_bal_q <= 1'b1;
              state     <= StIdle;
            end else begin
              valid_q   <= 1'b1;
              tag_id_q  <= id_shadow;
              balance_q <= bal_shadow;
              state     <= StHold;
            end
          end else if (gap_expired) begin
            frame_err_q <= 1'b1;
            id_shadow   <= '0;
            bal_shadow  <= '0;
            state       <= StIdle;
          end
        end
        StHold: begin
          // Bytes arriving here are dropped.
          if (hold_exit) begin
            valid_q <= 1'b0;
            state   <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.valid_Epass = valid_q;
  assign bus.tag_id      = tag_id_q;
  assign bus.balance     = balance_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.low_bal     = low_bal_q;
  assign bus.busy        = (state != StIdle);

endmodule
